pool_arb_sched: RTL and testbench

POOL_ARB_SCHED -- requirements
Module: pool_arb_sched

---
 rtl/pool_arb_sched.sv | 194 +++++++++++++++++++
 tb/tb_pool_arb_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pool_arb_sched.sv
// Round-robin arbiter and job scheduler sharing one pooling controller
// among N_REQ requesters. Handles job issue, completion, illegal-dimension
// aborts and a BUSY watchdog timeout. All outputs are registered.
module pool_arb_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*3-1:0]         req_inst,
    input  logic [N_REQ*3-1:0]         req_dim,
    input  logic                       pu_done,
    output logic                       start_pool,
    output logic [2:0]                 pooling_inst,
    output logic [2:0]                 array_dim,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           err,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [7:0]                 job_cnt
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Only dimensions 3, 4 and 5 can be handled by the pooling controller.
    function automatic logic dim_ok(input logic [2:0] d);
        dim_ok = (d == 3'd3) || (d == 3'd4) || (d == 3'd5);
    endfunction

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    function automatic logic [IW:0] pick(input logic [N_REQ-1:0] r,
                                         input logic [IW-1:0]    ptr);
        logic [IW:0] res;
        int          k;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N_REQ;
            if (r[k]) begin
                res = {1'b1, k[IW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t           r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [TW-1:0]    r_timer;
    logic             r_start;
    logic [2:0]       r_inst;
    logic [2:0]       r_dim;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_err;
    logic             r_busy;
    logic [IW-1:0]    r_owner;
    logic [7:0]       r_job_cnt;

    state_t           w_state_nxt;
    logic [IW-1:0]    w_rr_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic             w_start_nxt;
    logic [2:0]       w_inst_nxt;
    logic [2:0]       w_dim_nxt;
    logic [N_REQ-1:0] w_ack_nxt;
    logic [N_REQ-1:0] w_err_nxt;
    logic [IW-1:0]    w_owner_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [IW:0]      w_pick;
    logic [IW-1:0]    w_idx;
    logic [2:0]       w_sel_inst;
    logic [2:0]       w_sel_dim;
    logic [N_REQ-1:0] w_owner_oh;

    assign w_pick     = pick(req, r_rr_ptr);
    assign w_idx      = w_pick[IW-1:0];
    assign w_sel_inst = req_inst[int'(w_idx)*3 +: 3];
    assign w_sel_dim  = req_dim[int'(w_idx)*3 +: 3];
    assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_timer_nxt = r_timer;
        w_start_nxt = 1'b0;
        w_inst_nxt  = r_inst;
        w_dim_nxt   = r_dim;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_job_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick[IW]) begin
                    w_state_nxt = S_ISSUE;
                    w_rr_nxt    = (w_idx == IW'(N_REQ - 1)) ? '0 : (w_idx + IW'(1));
                    w_inst_nxt  = w_sel_inst;
                    w_dim_nxt   = w_sel_dim;
                    w_owner_nxt = w_idx;
                    w_start_nxt = dim_ok(w_sel_dim);
                end else begin
                    w_inst_nxt  = 3'd0;
                    w_dim_nxt   = 3'd0;
                    w_owner_nxt = '0;
                end
            end
            S_ISSUE: begin
                if (dim_ok(r_dim)) begin
                    w_state_nxt = S_BUSY;
                    w_timer_nxt = '0;
                end else begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = w_owner_oh;
                end
            end
            S_BUSY: begin
                if (pu_done) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = w_owner_oh;
                    w_cnt_nxt   = r_job_cnt + 8'd1;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = w_owner_oh;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
                w_inst_nxt  = 3'd0;
                w_dim_nxt   = 3'd0;
                w_owner_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
                w_inst_nxt  = 3'd0;
                w_dim_nxt   = 3'd0;
                w_owner_nxt = '0;
            end
        endcase
    end

    // State, pointer, timer and registered outputs; reset abandons any job.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_timer   <= '0;
            r_start   <= 1'b0;
            r_inst    <= 3'd0;
            r_dim     <= 3'd0;
            r_ack     <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_job_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_timer   <= w_timer_nxt;
            r_start   <= w_start_nxt;
            r_inst    <= w_inst_nxt;
            r_dim     <= w_dim_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_owner   <= w_owner_nxt;
            r_job_cnt <= w_cnt_nxt;
        end
    end

    assign start_pool   = r_start;
    assign pooling_inst = r_inst;
    assign array_dim    = r_dim;
    assign ack          = r_ack;
    assign err          = r_err;
    assign busy         = r_busy;
    assign owner        = r_owner;
    assign job_cnt      = r_job_cnt;

endmodule

// File: tb/tb_pool_arb_sched.sv
// Bench for pool_arb_sched: directed scenarios plus randomized jobs, checked
// against a job-level timeline model (grant order, event cycles, counters).
module tb_pool_arb_sched;

    localparam int N  = 4;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*3-1:0] req_inst = '0;
    logic [N*3-1:0] req_dim = '0;
    logic           pu_done = 1'b0;
    logic           start_pool;
    logic [2:0]     pooling_inst;
    logic [2:0]     array_dim;
    logic [N-1:0]   ack;
    logic [N-1:0]   err;
    logic           busy;
    logic [1:0]     owner;
    logic [7:0]     job_cnt;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;

    pool_arb_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst), .req(req), .req_inst(req_inst), .req_dim(req_dim),
        .pu_done(pu_done), .start_pool(start_pool), .pooling_inst(pooling_inst),
        .array_dim(array_dim), .ack(ack), .err(err), .busy(busy), .owner(owner),
        .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input int b, input int st, input int ei, input int ed,
                           input int own, input int ea, input int ee);
        chk("busy",         32'(busy),         32'(b));
        chk("start_pool",   32'(start_pool),   32'(st));
        chk("pooling_inst", 32'(pooling_inst), 32'(ei));
        chk("array_dim",    32'(array_dim),    32'(ed));
        chk("owner",        32'(owner),        32'(own));
        chk("ack",          32'(ack),          32'(ea));
        chk("err",          32'(err),          32'(ee));
        chk("job_cnt",      32'(job_cnt),      32'(m_cnt % 256));
    endtask

    // Random per-requester instruction/dimension; mostly legal dims.
    task automatic rand_cfg(input bit allow_illegal);
        for (int i = 0; i < N; i++) begin
            req_inst[i*3 +: 3] = 3'($urandom_range(7, 0));
            if (allow_illegal && ($urandom_range(3, 0) == 0))
                req_dim[i*3 +: 3] = 3'($urandom_range(7, 0));
            else
                req_dim[i*3 +: 3] = 3'($urandom_range(5, 3));
        end
    endtask

    // One job: called at a falling edge while the DUT is IDLE. k = BUSY cycle
    // index (0-based) carrying pu_done, k >= TO means never. rst_at = cycle
    // after grant at which nrst is pulsed (-1 = none).
    task automatic run_job(input logic [N-1:0] rv, input int k, input int rst_at,
                           input bit scramble);
        int g, cdone, ei, ed, oh;
        bit legal, is_ack;
        g = -1;
        for (int i = 0; i < N; i++)
            if (g < 0 && rv[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        req    = rv;
        ei     = int'(req_inst[g*3 +: 3]);
        ed     = int'(req_dim[g*3 +: 3]);
        legal  = (ed >= 3) && (ed <= 5);
        is_ack = legal && (k <= TO - 1);
        cdone  = !legal ? 2 : (is_ack ? k + 3 : TO + 2);
        oh     = 1 << g;
        m_ptr  = (g + 1) % N;
        for (int c = 1; c <= cdone + 1; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                nrst = 1'b0;
                #1;
                m_ptr = 0;
                m_cnt = 0;
                chk_all(0, 0, 0, 0, 0, 0, 0);
                pu_done = 1'b0;
                @(negedge clk);
                chk_all(0, 0, 0, 0, 0, 0, 0);
                nrst = 1'b1;
                return;
            end
            if (c == cdone && is_ack) m_cnt++;
            chk_all((c <= cdone) ? 1 : 0, (c == 1 && legal) ? 1 : 0,
                    (c <= cdone) ? ei : 0, (c <= cdone) ? ed : 0,
                    (c <= cdone) ? g : 0,
                    (c == cdone && is_ack) ? oh : 0,
                    (c == cdone && !is_ack) ? oh : 0);
            if (legal && c == k + 2)
                pu_done = 1'b1;
            else if (c == 1 || c == cdone)
                pu_done = 1'($urandom_range(1, 0));
            else
                pu_done = 1'b0;
            if (scramble && c == 1) begin
                rand_cfg(1'b1);
                if ($urandom_range(1, 0) == 1) req[g] = 1'b0;
            end
        end
        pu_done = 1'b0;
    endtask

    initial begin
        // Reset with all four requesters already pending, all dims legal.
        req = 4'hF;
        for (int i = 0; i < N; i++) begin
            req_inst[i*3 +: 3] = 3'(i + 1);
            req_dim[i*3 +: 3]  = 3'd4;
        end
        @(negedge clk);
        chk_all(0, 0, 0, 0, 0, 0, 0);
        nrst = 1'b1;

        // Round-robin under constant load: grants 0,1,2,3,0.
        for (int j = 0; j < 5; j++) run_job(4'hF, 3, -1, 1'b0);

        // Basic job: inst 5, dim 4, pu_done 8 cycles after start.
        req_inst[2:0] = 3'd5;
        req_dim[2:0]  = 3'd4;
        run_job(4'b0001, 7, -1, 1'b0);

        // Illegal dimension aborts without start.
        req_dim[8:6] = 3'd6;
        run_job(4'b0100, 3, -1, 1'b0);

        // Watchdog timeout.
        req_dim[5:3] = 3'd5;
        run_job(4'b0010, TO, -1, 1'b0);

        // pu_done coincides with the last timer value: done wins.
        req_dim[2:0] = 3'd3;
        run_job(4'b0001, TO - 1, -1, 1'b0);
        // One cycle before the last timer value, for contrast.
        run_job(4'b0001, TO - 2, -1, 1'b0);

        // Reset in BUSY, then arbitration restarts at requester 0.
        req_dim[5:3] = 3'd4;
        run_job(4'b0010, 20, 5, 1'b0);
        rand_cfg(1'b0);
        run_job(4'b0011, 2, -1, 1'b0);

        // Idle with no request: everything stays quiet, pu_done ignored.
        req = '0;
        for (int j = 0; j < 3; j++) begin
            pu_done = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk_all(0, 0, 0, 0, 0, 0, 0);
        end
        pu_done = 1'b0;

        // Randomized jobs with mid-job input changes and drops.
        for (int j = 0; j < 40; j++) begin
            int kk;
            logic [N-1:0] rv;
            rv = N'($urandom_range(15, 1));
            rand_cfg(1'b1);
            case ($urandom_range(9, 0))
                0:       kk = TO;
                1:       kk = TO - 1;
                2:       kk = TO - 2;
                default: kk = $urandom_range(12, 0);
            endcase
            run_job(rv, kk, -1, 1'b1);
        end

        // Enough quick completions to wrap job_cnt past 255.
        for (int j = 0; j < 260; j++) begin
            rand_cfg(1'b0);
            run_job(N'($urandom_range(15, 1)), 0, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
